signed_sat_add_pipe: RTL and testbench

//  Two-stage pipelined signed adder with overflow detection and saturation.

---
 rtl/sat_add_pkg.sv | 26 ++
 rtl/signed_ovf_sat.sv | 29 ++
 rtl/signed_sat_add_pipe.sv | 102 ++++++++++
 tb/tb_signed_sat_add_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_add_pkg.sv
// Shared types and helpers for the pipelined signed saturating adder.
// Payload fields are sized to MaxW and sign-extended so any W up to MaxW fits one struct.
package sat_add_pkg;

    localparam int unsigned MaxW = 32;

    typedef struct packed {
        logic [MaxW-1:0] max_val;
        logic [MaxW-1:0] min_val;
    } sat_limits_t;

    typedef struct packed {
        logic [MaxW-1:0] sum;
        logic            overflow;
        logic [MaxW-1:0] sat;
    } s2_payload_t;

    // MAX = 2^(w-1)-1 and MIN = -2^(w-1), both sign-extended to MaxW bits.
    function automatic sat_limits_t sat_limits(int unsigned w);
        sat_limits_t lim;
        lim.max_val = (MaxW'(1) << (w - 1)) - MaxW'(1);
        lim.min_val = ~lim.max_val;
        return lim;
    endfunction

endpackage

// File: rtl/signed_ovf_sat.sv
// Combinational W-bit signed add producing the wrapped sum, overflow flag and clamped sum.
module signed_ovf_sat
    import sat_add_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output s2_payload_t  payload_o
);

    logic [W-1:0]    sum_w;
    logic [MaxW-1:0] sum_x;
    logic            ovf;
    sat_limits_t     lim;

    always_comb begin
        sum_w = a_i + b_i;
        // Overflow only when both operands share a sign and the result's sign differs.
        ovf   = (a_i[W-1] == b_i[W-1]) && (sum_w[W-1] != a_i[W-1]);
        sum_x = MaxW'($signed(sum_w));
        lim   = sat_limits(W);

        payload_o.sum      = sum_x;
        payload_o.overflow = ovf;
        payload_o.sat      = ovf ? (a_i[W-1] ? lim.min_val : lim.max_val) : sum_x;
    end

endmodule

// File: rtl/signed_sat_add_pipe.sv
// Two-stage valid/ready pipelined signed adder with saturation and a sticky overflow counter.
module signed_sat_add_pipe
    import sat_add_pkg::*;
#(
    parameter int unsigned W       = 4,
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               up_valid,
    output logic               up_ready,
    input  logic [W-1:0]       up_a,
    input  logic [W-1:0]       up_b,
    output logic               down_valid,
    input  logic               down_ready,
    output logic [W-1:0]       down_sum,
    output logic               down_overflow,
    output logic [W-1:0]       down_sat,
    input  logic               ovf_clear,
    output logic [COUNT_W-1:0] ovf_count
);

    logic               s1_valid_q, s1_valid_d;
    logic [W-1:0]       s1_a_q, s1_a_d;
    logic [W-1:0]       s1_b_q, s1_b_d;
    logic               s2_valid_q, s2_valid_d;
    s2_payload_t        s2_q, s2_d;
    s2_payload_t        s1_result;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               s1_advance;
    logic               down_xfer;

    signed_ovf_sat #(
        .W(W)
    ) u_ovf_sat (
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .payload_o(s1_result)
    );

    always_comb begin
        down_xfer  = s2_valid_q & down_ready;
        s1_advance = !s2_valid_q | down_ready;
        up_ready   = !s1_valid_q | s1_advance;

        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;

        if (s1_advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_d = s1_result;
            end
        end

        if (up_ready) begin
            s1_valid_d = up_valid;
            if (up_valid) begin
                s1_a_d = up_a;
                s1_b_d = up_b;
            end
        end

        // Clear takes effect first so a same-cycle overflow transfer still counts.
        cnt_d = ovf_clear ? '0 : cnt_q;
        if (down_xfer && s2_q.overflow && (cnt_d != {COUNT_W{1'b1}})) begin
            cnt_d = cnt_d + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    // Data registers carry no reset; they are only observed alongside a set valid bit.
    always_ff @(posedge clk) begin
        s1_a_q <= s1_a_d;
        s1_b_q <= s1_b_d;
        s2_q   <= s2_d;
    end

    assign down_valid    = s2_valid_q;
    assign down_sum      = s2_q.sum[W-1:0];
    assign down_overflow = s2_q.overflow;
    assign down_sat      = s2_q.sat[W-1:0];
    assign ovf_count     = cnt_q;

    logic unused_s2_ext;
    assign unused_s2_ext = ^{s2_q.sum, s2_q.sat};

endmodule

// File: tb/tb_signed_sat_add_pipe.sv
// Scoreboard bench for signed_sat_add_pipe: directed cases, backpressure, counter, reset, random.
module tb_signed_sat_add_pipe;

    localparam int unsigned W       = 4;
    localparam int unsigned COUNT_W = 2;
    localparam int          CntMax  = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               up_valid;
    logic               up_ready;
    logic [W-1:0]       up_a;
    logic [W-1:0]       up_b;
    logic               down_valid;
    logic               down_ready;
    logic [W-1:0]       down_sum;
    logic               down_overflow;
    logic [W-1:0]       down_sat;
    logic               ovf_clear;
    logic [COUNT_W-1:0] ovf_count;

    typedef struct {
        logic [W-1:0] sum;
        logic         ovf;
        logic [W-1:0] sat;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   exp_cnt  = 0;
    int   rdy_mode = 1;  // 0: always ready, 1: never ready, 2: random

    signed_sat_add_pipe #(
        .W      (W),
        .COUNT_W(COUNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .up_valid     (up_valid),
        .up_ready     (up_ready),
        .up_a         (up_a),
        .up_b         (up_b),
        .down_valid   (down_valid),
        .down_ready   (down_ready),
        .down_sum     (down_sum),
        .down_overflow(down_overflow),
        .down_sat     (down_sat),
        .ovf_clear    (ovf_clear),
        .ovf_count    (ovf_count)
    );

    always #5 clk = ~clk;

    // Reference: exact integer sum, then wrap or clamp into the W-bit signed range.
    function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b);
        exp_t e;
        int   s;
        int   hi;
        int   lo;
        hi    = (1 << (W - 1)) - 1;
        lo    = -(1 << (W - 1));
        s     = int'($signed(a)) + int'($signed(b));
        e.ovf = (s > hi) || (s < lo);
        e.sum = W'(s);
        if (s > hi) e.sat = W'(hi);
        else if (s < lo) e.sat = W'(lo);
        else e.sat = W'(s);
        return e;
    endfunction

    function automatic exp_t mk(logic [W-1:0] sum, logic ovf, logic [W-1:0] sat);
        exp_t e;
        e.sum = sum;
        e.ovf = ovf;
        e.sat = sat;
        return e;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_exp(logic [W-1:0] a, logic [W-1:0] b, exp_t e);
        int waited = 0;
        bit done   = 1'b0;
        up_valid = 1'b1;
        up_a     = a;
        up_b     = b;
        while (!done) begin
            @(negedge clk);
            if (up_ready) begin
                exp_q.push_back(e);
                done = 1'b1;
            end else if (waited >= 200) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: up_ready stuck at 0 for %0d cycles", waited);
                done = 1'b1;
            end
            waited++;
            @(posedge clk);
            #1;
        end
        up_valid = 1'b0;
    endtask

    task automatic send(logic [W-1:0] a, logic [W-1:0] b);
        send_exp(a, b, model(a, b));
    endtask

    task automatic drain();
        rdy_mode = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("drain_left", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin : ready_gen
        down_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       down_ready = 1'b1;
                1:       down_ready = 1'b0;
                default: down_ready = ($urandom_range(0, 99) < 70);
            endcase
        end
    end

    initial begin : monitor
        bit           held;
        logic [W-1:0] h_sum;
        logic [W-1:0] h_sat;
        logic         h_ovf;
        exp_t         e;
        int           nxt;
        bit           ovf_out;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held    = 1'b0;
                exp_cnt = 0;
            end else begin
                check("ovf_count", ovf_count, exp_cnt);
                if (held) begin
                    check("stall_stable", {down_valid, down_sum, down_overflow, down_sat},
                          {1'b1, h_sum, h_ovf, h_sat});
                end
                held    = 1'b0;
                ovf_out = 1'b0;
                if (down_valid) begin
                    if (down_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_output: sum=0x%0h with empty scoreboard",
                                     down_sum);
                        end else begin
                            e = exp_q.pop_front();
                            check("result", {down_sum, down_overflow, down_sat},
                                  {e.sum, e.ovf, e.sat});
                            ovf_out = e.ovf;
                        end
                    end else begin
                        held  = 1'b1;
                        h_sum = down_sum;
                        h_ovf = down_overflow;
                        h_sat = down_sat;
                    end
                end
                nxt = ovf_clear ? 0 : exp_cnt;
                if (ovf_out) nxt = (nxt + 1 > CntMax) ? CntMax : nxt + 1;
                exp_cnt = nxt;
            end
        end
    end

    initial begin : watchdog
        #4000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        rst_n     = 1'b0;
        up_valid  = 1'b0;
        up_a      = '0;
        up_b      = '0;
        ovf_clear = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_down_valid", down_valid, 0);
        check("rst_ovf_count", ovf_count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_up_ready", up_ready, 1);
        @(posedge clk);
        #1;

        // Overflow cases and two-cycle latency
        rdy_mode = 0;
        send_exp(4'd4, 4'd7, mk(4'b1011, 1'b1, 4'd7));
        @(negedge clk);
        check("latency_s1", down_valid, 0);
        @(negedge clk);
        check("latency_s2", down_valid, 1);
        @(posedge clk);
        #1;
        send_exp(4'hC, 4'h9, mk(4'h5, 1'b1, 4'h8));

        // Non-overflow boundaries
        send_exp(4'd3, 4'hB, mk(4'hE, 1'b0, 4'hE));
        send_exp(4'd4, 4'hC, mk(4'h0, 1'b0, 4'h0));
        send_exp(4'hC, 4'hC, mk(4'h8, 1'b0, 4'h8));
        drain();

        // Backpressure: two pairs held, third refused, outputs stable
        rdy_mode = 1;
        tick(1);
        send(4'd1, 4'd2);
        send(4'd3, 4'd3);
        up_valid = 1'b1;
        up_a     = 4'd5;
        up_b     = 4'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_up_ready", up_ready, 0);
            @(posedge clk);
            #1;
        end
        rdy_mode = 0;
        send(4'd5, 4'd5);
        drain();

        // Counter saturation, then clear with concurrent overflow transfer
        ovf_clear = 1'b1;
        tick(1);
        ovf_clear = 1'b0;
        send(4'd7, 4'd7);
        send(4'h8, 4'h8);
        send(4'd5, 4'd5);
        send(4'h9, 4'hA);
        send(4'd6, 4'd3);
        drain();
        @(negedge clk);
        check("cnt_saturated", ovf_count, CntMax);
        @(posedge clk);
        #1;
        rdy_mode = 1;
        tick(1);
        send(4'd7, 4'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (down_valid) break;
        end
        check("clr_wait_valid", down_valid, 1);
        @(posedge clk);
        #1;
        ovf_clear = 1'b1;
        rdy_mode  = 0;
        @(posedge clk);
        #1;
        ovf_clear = 1'b0;
        @(negedge clk);
        check("clr_and_count", ovf_count, 1);
        @(posedge clk);
        #1;

        // Reset with two pairs in flight
        rdy_mode = 1;
        tick(1);
        send(4'd7, 4'd1);
        send(4'd2, 4'd2);
        rst_n = 1'b0;
        #1;
        check("midrst_down_valid", down_valid, 0);
        check("midrst_ovf_count", ovf_count, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_up_ready", up_ready, 1);
        check("midrst_no_output", down_valid, 0);
        rdy_mode = 0;
        tick(5);

        // Random regression
        rdy_mode = 2;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 9) < 3) tick(1);
            ovf_clear = ($urandom_range(0, 49) == 0);
            send(W'($urandom), W'($urandom));
        end
        ovf_clear = 1'b0;
        drain();
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
